// File: rtl/uctl_ahb_rx_pkg.sv
// Shared types and constants for the AHB receive-side burst controller.
// State encodings, AHB HSIZE codes and the 1 KB burst boundary.
package uctl_ahb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    THRESH = 3'd1,
    REQ    = 3'd2,
    ADDRWT = 3'd3,
    WTDDN  = 3'd4,
    ABRTWT = 3'd5
  } ctrlState_t;

  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HWORD = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] DWORD = 3'b011;

  localparam int unsigned AHB_BOUNDARY = 1024;

endpackage

// File: rtl/uctl_ahb_rx_burst_calc.sv
// Combinational burst sizing: picks head/body/tail burst shape from the
// remaining byte count and the low address bits.
module uctl_ahb_rx_burst_calc
  import uctl_ahb_rx_pkg::*;
#(
  parameter int CNTR_WD   = 20,
  parameter int DATA_SIZE = 32,
  parameter int MAX_BEATS = 16,
  parameter int BEAT_WD   = $clog2(MAX_BEATS) + 1
) (
  input  logic [CNTR_WD-1:0] nB,
  input  logic [9:0]         addrLo,
  output logic [BEAT_WD-1:0] beats,
  output logic [2:0]         hSize,
  output logic [CNTR_WD-1:0] consumed,
  output logic [BEAT_WD-1:0] wordsNeeded
);

  localparam int BPW    = DATA_SIZE / 8;
  localparam int OFF_WD = $clog2(BPW);
  localparam logic [CNTR_WD-1:0] BPW_C   = CNTR_WD'(BPW);
  localparam logic [CNTR_WD-1:0] MAXB_C  = CNTR_WD'(MAX_BEATS);
  localparam logic [CNTR_WD-1:0] BOUND_C = CNTR_WD'(AHB_BOUNDARY);
  localparam logic [2:0] BODY_HSIZE = (DATA_SIZE == 64) ? DWORD : WORD;

  logic [CNTR_WD-1:0] off_s;
  logic [CNTR_WD-1:0] headRoom_s;
  logic [CNTR_WD-1:0] bodyWords_s;
  logic [CNTR_WD-1:0] bndWords_s;
  logic [CNTR_WD-1:0] beatsFull_s;

  function automatic logic [CNTR_WD-1:0] minOf(input logic [CNTR_WD-1:0] a,
                                               input logic [CNTR_WD-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign off_s       = CNTR_WD'(addrLo[OFF_WD-1:0]);
  assign headRoom_s  = BPW_C - off_s;
  assign bodyWords_s = nB >> OFF_WD;
  // Words left before the next 1 KB boundary; address is word aligned here.
  assign bndWords_s  = (BOUND_C - CNTR_WD'(addrLo)) >> OFF_WD;

  // Select head, body or tail burst shape.
  always_comb begin
    beatsFull_s = nB;
    hSize       = BYTE;
    consumed    = nB;
    wordsNeeded = BEAT_WD'(1'b1);
    if (off_s != '0) begin
      beatsFull_s = minOf(nB, headRoom_s);
      hSize       = BYTE;
      consumed    = beatsFull_s;
      wordsNeeded = BEAT_WD'(1'b1);
    end else if (nB >= BPW_C) begin
      beatsFull_s = minOf(minOf(bodyWords_s, MAXB_C), bndWords_s);
      hSize       = BODY_HSIZE;
      consumed    = beatsFull_s << OFF_WD;
      wordsNeeded = beatsFull_s[BEAT_WD-1:0];
    end else begin
      beatsFull_s = nB;
      hSize       = BYTE;
      consumed    = nB;
      wordsNeeded = BEAT_WD'(1'b1);
    end
    beats = beatsFull_s[BEAT_WD-1:0];
  end

endmodule

// File: rtl/uctl_ahb_rx_burst_ctrl.sv
// AHB receive-side transfer controller: splits a DMA request into
// FIFO-gated AHB sub-bursts, with clean abort and completion pulses.
module uctl_ahb_rx_burst_ctrl
  import uctl_ahb_rx_pkg::*;
#(
  parameter int CNTR_WD   = 20,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int MAX_BEATS = 16,
  parameter int FIFO_WD   = 6,
  parameter int BEAT_WD   = $clog2(MAX_BEATS) + 1
) (
  input  logic                 uctl_sysClk,
  input  logic                 uctl_sysRst_n,
  input  logic [CNTR_WD-1:0]   dmaRx2ctrl_len,
  input  logic                 dmaRx2ctrl_sRdWr,
  input  logic                 dmaRx2ctrl_stransEn,
  input  logic [ADDR_SIZE-1:0] dmaRx2ctrl_sWrAddr,
  input  logic                 dmaRx2ctrl_abort,
  output logic                 ctrl2dmaRx_dn,
  output logic                 ctrl2dmaRx_aborted,
  output logic                 ctrl2dmaRx_busy,
  input  logic [FIFO_WD-1:0]   words_inFifo,
  input  logic                 ahbc2ctrl_ack,
  input  logic                 ahbc2ctrl_addrDn,
  input  logic                 ahbc2ctrl_dataDn,
  output logic                 ctrl2ahbc_trEn,
  output logic [BEAT_WD-1:0]   ctrl2ahbc_beats,
  output logic [2:0]           ctrl2ahbc_hSize,
  output logic [ADDR_SIZE-1:0] ctrl2ahbc_sWrAddr,
  output logic                 ctrl2ahbc_sRdWr
);

  ctrlState_t state_r, state_s;
  logic [CNTR_WD-1:0]   nB_r, nB_s;
  logic [ADDR_SIZE-1:0] addr_r, addr_s;
  logic                 rdWr_r, rdWr_s;
  logic                 issued_r, issued_s;
  logic                 abortPend_r, abortPend_s;
  logic                 trEn_r, trEn_s;
  logic [BEAT_WD-1:0]   beats_r, beats_s;
  logic [2:0]           hSize_r, hSize_s;
  logic [ADDR_SIZE-1:0] sWrAddr_r, sWrAddr_s;
  logic                 dn_r, dn_s;
  logic                 aborted_r, aborted_s;
  logic                 busy_r;

  logic [BEAT_WD-1:0] calcBeats_s;
  logic [2:0]         calcHSize_s;
  logic [CNTR_WD-1:0] consumed_s;
  logic [BEAT_WD-1:0] wordsNeeded_s;
  logic               threshold_s;

  uctl_ahb_rx_burst_calc #(
    .CNTR_WD   (CNTR_WD),
    .DATA_SIZE (DATA_SIZE),
    .MAX_BEATS (MAX_BEATS),
    .BEAT_WD   (BEAT_WD)
  ) u_calc (
    .nB          (nB_r),
    .addrLo      (addr_r[9:0]),
    .beats       (calcBeats_s),
    .hSize       (calcHSize_s),
    .consumed    (consumed_s),
    .wordsNeeded (wordsNeeded_s)
  );

  assign threshold_s = (32'(words_inFifo) >= 32'(wordsNeeded_s));

  // Next-state and next-register values for the transfer FSM.
  always_comb begin
    state_s     = state_r;
    nB_s        = nB_r;
    addr_s      = addr_r;
    rdWr_s      = rdWr_r;
    issued_s    = issued_r;
    abortPend_s = abortPend_r;
    trEn_s      = trEn_r;
    beats_s     = beats_r;
    hSize_s     = hSize_r;
    sWrAddr_s   = sWrAddr_r;
    dn_s        = 1'b0;
    aborted_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dmaRx2ctrl_stransEn) begin
          nB_s        = dmaRx2ctrl_len;
          addr_s      = dmaRx2ctrl_sWrAddr;
          rdWr_s      = dmaRx2ctrl_sRdWr;
          issued_s    = 1'b0;
          abortPend_s = 1'b0;
          state_s     = THRESH;
        end else begin
          state_s = IDLE;
        end
      end
      THRESH: begin
        if (abortPend_r || dmaRx2ctrl_abort) begin
          state_s = ABRTWT;
        end else if (nB_r == '0) begin
          // Done only once the data phase of the last burst has drained.
          if (!issued_r || ahbc2ctrl_dataDn) begin
            dn_s    = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WTDDN;
          end
        end else if (threshold_s) begin
          trEn_s    = 1'b1;
          beats_s   = calcBeats_s;
          hSize_s   = calcHSize_s;
          sWrAddr_s = addr_r;
          state_s   = REQ;
        end else begin
          state_s = THRESH;
        end
      end
      REQ: begin
        if (dmaRx2ctrl_abort) begin
          abortPend_s = 1'b1;
        end else begin
          abortPend_s = abortPend_r;
        end
        if (ahbc2ctrl_ack) begin
          trEn_s   = 1'b0;
          nB_s     = nB_r - consumed_s;
          addr_s   = addr_r + ADDR_SIZE'(consumed_s);
          issued_s = 1'b1;
          state_s  = ahbc2ctrl_addrDn ? THRESH : ADDRWT;
        end else begin
          state_s = REQ;
        end
      end
      ADDRWT: begin
        if (dmaRx2ctrl_abort) begin
          abortPend_s = 1'b1;
        end else begin
          abortPend_s = abortPend_r;
        end
        if (ahbc2ctrl_addrDn) begin
          state_s = THRESH;
        end else begin
          state_s = ADDRWT;
        end
      end
      WTDDN: begin
        if (ahbc2ctrl_dataDn) begin
          dn_s    = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WTDDN;
        end
      end
      ABRTWT: begin
        trEn_s = 1'b0;
        if (!issued_r || ahbc2ctrl_dataDn) begin
          aborted_s   = 1'b1;
          nB_s        = '0;
          abortPend_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = ABRTWT;
        end
      end
      default: begin
        trEn_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge uctl_sysClk) begin
    if (!uctl_sysRst_n) begin
      state_r     <= IDLE;
      nB_r        <= '0;
      addr_r      <= '0;
      rdWr_r      <= 1'b0;
      issued_r    <= 1'b0;
      abortPend_r <= 1'b0;
      trEn_r      <= 1'b0;
      beats_r     <= '0;
      hSize_r     <= 3'b000;
      sWrAddr_r   <= '0;
      dn_r        <= 1'b0;
      aborted_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      nB_r        <= nB_s;
      addr_r      <= addr_s;
      rdWr_r      <= rdWr_s;
      issued_r    <= issued_s;
      abortPend_r <= abortPend_s;
      trEn_r      <= trEn_s;
      beats_r     <= beats_s;
      hSize_r     <= hSize_s;
      sWrAddr_r   <= sWrAddr_s;
      dn_r        <= dn_s;
      aborted_r   <= aborted_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign ctrl2dmaRx_dn      = dn_r;
  assign ctrl2dmaRx_aborted = aborted_r;
  assign ctrl2dmaRx_busy    = busy_r;
  assign ctrl2ahbc_trEn     = trEn_r;
  assign ctrl2ahbc_beats    = beats_r;
  assign ctrl2ahbc_hSize    = hSize_r;
  assign ctrl2ahbc_sWrAddr  = sWrAddr_r;
  assign ctrl2ahbc_sRdWr    = rdWr_r;

endmodule

// File: tb/tb_uctl_ahb_rx_burst_ctrl.sv
// Scoreboard bench for uctl_ahb_rx_burst_ctrl: expected bursts are queued at
// request time and checked as the controller issues them to a simple AHB core model.
module tb_uctl_ahb_rx_burst_ctrl;

  localparam int CNTR_WD   = 20;
  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 32;
  localparam int MAX_BEATS = 16;
  localparam int FIFO_WD   = 6;
  localparam int BEAT_WD   = 5;
  localparam logic [2:0] H_BYTE = 3'b000;
  localparam logic [2:0] H_WORD = 3'b010;

  logic                 uctl_sysClk = 1'b0;
  logic                 uctl_sysRst_n;
  logic [CNTR_WD-1:0]   dmaRx2ctrl_len;
  logic                 dmaRx2ctrl_sRdWr;
  logic                 dmaRx2ctrl_stransEn;
  logic [ADDR_SIZE-1:0] dmaRx2ctrl_sWrAddr;
  logic                 dmaRx2ctrl_abort;
  logic                 ctrl2dmaRx_dn;
  logic                 ctrl2dmaRx_aborted;
  logic                 ctrl2dmaRx_busy;
  logic [FIFO_WD-1:0]   words_inFifo;
  logic                 ahbc2ctrl_ack;
  logic                 ahbc2ctrl_addrDn;
  logic                 ahbc2ctrl_dataDn;
  logic                 ctrl2ahbc_trEn;
  logic [BEAT_WD-1:0]   ctrl2ahbc_beats;
  logic [2:0]           ctrl2ahbc_hSize;
  logic [ADDR_SIZE-1:0] ctrl2ahbc_sWrAddr;
  logic                 ctrl2ahbc_sRdWr;

  uctl_ahb_rx_burst_ctrl #(
    .CNTR_WD (CNTR_WD), .ADDR_SIZE (ADDR_SIZE), .DATA_SIZE (DATA_SIZE),
    .MAX_BEATS (MAX_BEATS), .FIFO_WD (FIFO_WD), .BEAT_WD (BEAT_WD)
  ) dut (
    .uctl_sysClk         (uctl_sysClk),
    .uctl_sysRst_n       (uctl_sysRst_n),
    .dmaRx2ctrl_len      (dmaRx2ctrl_len),
    .dmaRx2ctrl_sRdWr    (dmaRx2ctrl_sRdWr),
    .dmaRx2ctrl_stransEn (dmaRx2ctrl_stransEn),
    .dmaRx2ctrl_sWrAddr  (dmaRx2ctrl_sWrAddr),
    .dmaRx2ctrl_abort    (dmaRx2ctrl_abort),
    .ctrl2dmaRx_dn       (ctrl2dmaRx_dn),
    .ctrl2dmaRx_aborted  (ctrl2dmaRx_aborted),
    .ctrl2dmaRx_busy     (ctrl2dmaRx_busy),
    .words_inFifo        (words_inFifo),
    .ahbc2ctrl_ack       (ahbc2ctrl_ack),
    .ahbc2ctrl_addrDn    (ahbc2ctrl_addrDn),
    .ahbc2ctrl_dataDn    (ahbc2ctrl_dataDn),
    .ctrl2ahbc_trEn      (ctrl2ahbc_trEn),
    .ctrl2ahbc_beats     (ctrl2ahbc_beats),
    .ctrl2ahbc_hSize     (ctrl2ahbc_hSize),
    .ctrl2ahbc_sWrAddr   (ctrl2ahbc_sWrAddr),
    .ctrl2ahbc_sRdWr     (ctrl2ahbc_sRdWr)
  );

  always #5 uctl_sysClk = ~uctl_sysClk;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  beats;
    logic [2:0]  hSize;
  } burst_t;

  burst_t expQ[$];
  int     vecCnt = 0;
  int     errCnt = 0;
  logic   expRdWr = 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] allOuts();
    return 64'({ctrl2dmaRx_dn, ctrl2dmaRx_aborted, ctrl2dmaRx_busy, ctrl2ahbc_trEn,
                ctrl2ahbc_beats, ctrl2ahbc_hSize, ctrl2ahbc_sWrAddr, ctrl2ahbc_sRdWr});
  endfunction

  task automatic pushB(input logic [31:0] a, input logic [4:0] b, input logic [2:0] h);
    burst_t e;
    e.addr = a; e.beats = b; e.hSize = h;
    expQ.push_back(e);
  endtask

  // Called at a falling edge; the request is seen on the following rising edge.
  task automatic startXfer(input logic [31:0] a, input logic [19:0] n, input logic rw);
    dmaRx2ctrl_sWrAddr  = a;
    dmaRx2ctrl_len      = n;
    dmaRx2ctrl_sRdWr    = rw;
    expRdWr             = rw;
    dmaRx2ctrl_stransEn = 1'b1;
    @(negedge uctl_sysClk);
    dmaRx2ctrl_stransEn = 1'b0;
  endtask

  // AHB core model: acks each burst after ackDly hold cycles, reports addrDn
  // with the ack or one cycle later, and signals dataDn after the final burst.
  task automatic serviceBursts(input bit coinc, input int ackDly, input logic [31:0] expBytes);
    burst_t      cur;
    int          hold, lastAck, dataCnt, dnCnt, dnCyc, abCnt;
    bit          pendAddr, inBurst;
    logic [31:0] byteSum;
    cur = '0; hold = 0; lastAck = -1; dataCnt = -1; dnCnt = 0; dnCyc = -1; abCnt = 0;
    pendAddr = 1'b0; inBurst = 1'b0; byteSum = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (ctrl2dmaRx_dn) begin
        dnCnt++;
        if (dnCyc < 0) dnCyc = cyc;
      end
      if (ctrl2dmaRx_aborted) abCnt++;
      ahbc2ctrl_ack = 1'b0; ahbc2ctrl_addrDn = 1'b0; ahbc2ctrl_dataDn = 1'b0;
      if (ctrl2ahbc_trEn) begin
        if (!inBurst) begin
          inBurst = 1'b1; hold = 0;
          if (expQ.size() == 0) begin
            checkVal("extraBurst", 64'(ctrl2ahbc_trEn), 64'd0);
          end else begin
            cur = expQ.pop_front();
            checkVal("burstAddr",  64'(ctrl2ahbc_sWrAddr), 64'(cur.addr));
            checkVal("burstBeats", 64'(ctrl2ahbc_beats),   64'(cur.beats));
            checkVal("burstHSize", 64'(ctrl2ahbc_hSize),   64'(cur.hSize));
            checkVal("burstRdWr",  64'(ctrl2ahbc_sRdWr),   64'(expRdWr));
            if (coinc && lastAck >= 0) checkVal("burstGap", 64'(cyc - lastAck), 64'd2);
          end
          byteSum += 32'(ctrl2ahbc_beats) << ctrl2ahbc_hSize;
        end else begin
          checkVal("holdAddr",  64'(ctrl2ahbc_sWrAddr), 64'(cur.addr));
          checkVal("holdBeats", 64'(ctrl2ahbc_beats),   64'(cur.beats));
        end
        if (hold == ackDly) begin
          ahbc2ctrl_ack = 1'b1; ahbc2ctrl_addrDn = coinc; pendAddr = !coinc;
          inBurst = 1'b0; lastAck = cyc;
          if (expQ.size() == 0) dataCnt = 3;
        end else begin
          hold++;
        end
      end else if (pendAddr) begin
        ahbc2ctrl_addrDn = 1'b1; pendAddr = 1'b0;
      end
      if (dataCnt == 0) begin
        ahbc2ctrl_dataDn = 1'b1; dataCnt = -1;
      end else if (dataCnt > 0) begin
        dataCnt--;
      end
      if (dnCyc >= 0 && cyc >= dnCyc + 3) break;
      @(negedge uctl_sysClk);
    end
    ahbc2ctrl_ack = 1'b0; ahbc2ctrl_addrDn = 1'b0; ahbc2ctrl_dataDn = 1'b0;
    checkVal("dnCount",      64'(dnCnt), 64'd1);
    checkVal("abortedCount", 64'(abCnt), 64'd0);
    checkVal("burstsLeft",   64'(expQ.size()), 64'd0);
    checkVal("byteTotal",    64'(byteSum), 64'(expBytes));
    checkVal("idleBusy",     64'(ctrl2dmaRx_busy), 64'd0);
    expQ.delete();
  endtask

  task automatic waitTrEn(input string tag);
    for (int i = 0; i < 20 && !ctrl2ahbc_trEn; i++) @(negedge uctl_sysClk);
    checkVal(tag, 64'(ctrl2ahbc_trEn), 64'd1);
  endtask

  initial begin
    int dnCnt, trCnt;
    uctl_sysRst_n = 1'b0;
    dmaRx2ctrl_len = '0; dmaRx2ctrl_sRdWr = 1'b0; dmaRx2ctrl_stransEn = 1'b0;
    dmaRx2ctrl_sWrAddr = '0; dmaRx2ctrl_abort = 1'b0; words_inFifo = 6'd63;
    ahbc2ctrl_ack = 1'b0; ahbc2ctrl_addrDn = 1'b0; ahbc2ctrl_dataDn = 1'b0;
    repeat (2) @(negedge uctl_sysClk);
    checkVal("resetOuts", allOuts(), 64'd0);
    uctl_sysRst_n = 1'b1;
    @(negedge uctl_sysClk);

    // Long aligned transfer
    pushB(32'h1000, 5'd16, H_WORD); pushB(32'h1040, 5'd16, H_WORD);
    pushB(32'h1080, 5'd16, H_WORD); pushB(32'h10C0, 5'd2, H_WORD);
    startXfer(32'h1000, 20'd200, 1'b1);
    serviceBursts(1'b1, 0, 32'd200);

    // Unaligned start with head and tail bursts
    pushB(32'h2003, 5'd1, H_BYTE); pushB(32'h2004, 5'd2, H_WORD); pushB(32'h200C, 5'd1, H_BYTE);
    startXfer(32'h2003, 20'd10, 1'b0);
    serviceBursts(1'b0, 2, 32'd10);

    // 1 KB boundary split
    pushB(32'h33F0, 5'd4, H_WORD); pushB(32'h3400, 5'd12, H_WORD);
    startXfer(32'h33F0, 20'd64, 1'b1);
    serviceBursts(1'b1, 1, 32'd64);

    // FIFO threshold one word short, then just enough
    words_inFifo = 6'd15;
    startXfer(32'h4000, 20'd64, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkVal("thrHold", 64'(ctrl2ahbc_trEn), 64'd0);
      @(negedge uctl_sysClk);
    end
    words_inFifo = 6'd16;
    @(negedge uctl_sysClk);
    checkVal("thrRise",  64'(ctrl2ahbc_trEn),  64'd1);
    checkVal("thrBeats", 64'(ctrl2ahbc_beats), 64'd16);
    pushB(32'h4000, 5'd16, H_WORD);
    serviceBursts(1'b1, 0, 32'd64);
    words_inFifo = 6'd63;

    // Abort latched while waiting for the address phase
    startXfer(32'h5000, 20'd128, 1'b0);
    waitTrEn("abortFirstTrEn");
    checkVal("abortFirstAddr", 64'(ctrl2ahbc_sWrAddr), 64'h5000);
    ahbc2ctrl_ack = 1'b1;
    @(negedge uctl_sysClk);
    ahbc2ctrl_ack = 1'b0; dmaRx2ctrl_abort = 1'b1;
    @(negedge uctl_sysClk);
    dmaRx2ctrl_abort = 1'b0; ahbc2ctrl_addrDn = 1'b1;
    @(negedge uctl_sysClk);
    ahbc2ctrl_addrDn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkVal("abortNoTrEn",   64'(ctrl2ahbc_trEn),     64'd0);
      checkVal("abortNoDn",     64'(ctrl2dmaRx_dn),      64'd0);
      checkVal("abortEarly",    64'(ctrl2dmaRx_aborted), 64'd0);
      @(negedge uctl_sysClk);
    end
    ahbc2ctrl_dataDn = 1'b1;
    @(negedge uctl_sysClk);
    ahbc2ctrl_dataDn = 1'b0;
    checkVal("abortPulse",  64'(ctrl2dmaRx_aborted), 64'd1);
    checkVal("abortDnExcl", 64'(ctrl2dmaRx_dn),      64'd0);
    checkVal("abortIdle",   64'(ctrl2dmaRx_busy),    64'd0);
    @(negedge uctl_sysClk);
    checkVal("abortOneCyc", 64'(ctrl2dmaRx_aborted), 64'd0);

    // Zero-length request completes without any burst
    startXfer(32'h8000, 20'd0, 1'b0);
    dnCnt = 0; trCnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (ctrl2dmaRx_dn) dnCnt++;
      if (ctrl2ahbc_trEn) trCnt++;
      @(negedge uctl_sysClk);
    end
    checkVal("zeroLenDn",   64'(dnCnt), 64'd1);
    checkVal("zeroLenTrEn", 64'(trCnt), 64'd0);

    // Reset asserted while a burst request is pending
    startXfer(32'h7000, 20'd200, 1'b1);
    waitTrEn("rstTrEn");
    uctl_sysRst_n = 1'b0;
    @(negedge uctl_sysClk);
    uctl_sysRst_n = 1'b1;
    checkVal("rstMidOuts", allOuts(), 64'd0);
    pushB(32'h6000, 5'd2, H_WORD);
    startXfer(32'h6000, 20'd8, 1'b0);
    serviceBursts(1'b1, 0, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
